// File: rtl/cnn_layer_accel_wht_bank_array_pkg.sv
// Shared types and constants for the double-banked CNN weight store.
package cnn_layer_accel_wht_bank_array_pkg;

    localparam int unsigned TAP_W    = 4;
    localparam int unsigned MAX_TAPS = 16;

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_LOAD = 2'd1,
        CFG_FULL = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/cnn_layer_accel_wht_ce_port.sv
// One compute engine's private weight RAM copy with its read-address delay line.
module cnn_layer_accel_wht_ce_port #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_DELAY = 3,
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [ADDR_DELAY];
    logic [DATA_W-1:0] data_q [RD_LATENCY];

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ADDR_DELAY); i++) addr_q[i] <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) data_q[i] <= '0;
        end else begin
            addr_q[0] <= rd_addr_i;
            for (int i = 1; i < int'(ADDR_DELAY); i++) addr_q[i] <= addr_q[i-1];
            data_q[0] <= mem_q[addr_q[ADDR_DELAY-1]];
            for (int i = 1; i < int'(RD_LATENCY); i++) data_q[i] <= data_q[i-1];
        end
    end

    assign rd_data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/cnn_layer_accel_wht_bank_array.sv
// Ping-pong weight banks: one bank loads from the config stream while the other feeds all CEs.
module cnn_layer_accel_wht_bank_array
    import cnn_layer_accel_wht_bank_array_pkg::*;
#(
    parameter int unsigned C_NUM_CE         = 2,
    parameter int unsigned C_WHT_WIDTH      = 16,
    parameter int unsigned C_MAX_GROUPS     = 64,
    parameter int unsigned C_SEQ_ADDR_DELAY = 3,
    parameter int unsigned C_RD_LATENCY     = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_start,
    input  logic [$clog2(C_MAX_GROUPS)-1:0]   cfg_num_groups,
    input  logic [4:0]                        cfg_num_taps,
    input  logic                              cfg_wren,
    input  logic [C_WHT_WIDTH-1:0]            cfg_data,
    output logic                              cfg_ready,
    output logic                              cfg_done,
    input  logic                              job_accept,
    output logic                              job_ready,
    input  logic                              ce_execute,
    input  logic [C_NUM_CE*TAP_W-1:0]         ce_seq_addr,
    input  logic                              next_kernel,
    output logic                              last_kernel,
    output logic [C_NUM_CE*C_WHT_WIDTH-1:0]   ce_wht_dout,
    output logic                              ce_wht_dout_valid
);

    localparam int unsigned GRP_W  = $clog2(C_MAX_GROUPS);
    localparam int unsigned ADDR_W = 1 + GRP_W + TAP_W;
    localparam int unsigned DEPTH  = 2 * C_MAX_GROUPS * MAX_TAPS;
    localparam int unsigned LAT    = C_SEQ_ADDR_DELAY + C_RD_LATENCY;

    cfg_state_t         state_q;
    logic               cfg_ready_q, job_ready_q, cfg_done_q;
    logic               cfg_bank_q, exe_bank_q;
    logic [GRP_W-1:0]   wr_group_q, ld_groups_q, exe_groups_q, exe_group_q;
    logic [TAP_W-1:0]   wr_tap_q, ld_taps_m1_q;
    logic [LAT-1:0]     valid_q, last_q;

    logic               wr_en;
    logic               final_wr;
    logic               swap;
    logic [ADDR_W-1:0]  wr_addr;

    // cfg_start wins over a coincident write so a restart always begins at {0,0}.
    assign wr_en    = (state_q == CFG_LOAD) && cfg_wren && !cfg_start;
    assign final_wr = wr_en && (wr_group_q == ld_groups_q) && (wr_tap_q == ld_taps_m1_q);
    assign swap     = (state_q == CFG_FULL) && job_accept;
    assign wr_addr  = {cfg_bank_q, wr_group_q, wr_tap_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CFG_IDLE;
            cfg_ready_q  <= 1'b1;
            job_ready_q  <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_bank_q   <= 1'b0;
            exe_bank_q   <= 1'b0;
            wr_group_q   <= '0;
            wr_tap_q     <= '0;
            ld_groups_q  <= '0;
            ld_taps_m1_q <= '0;
            exe_groups_q <= '0;
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                CFG_IDLE, CFG_LOAD: begin
                    if (cfg_start) begin
                        state_q      <= CFG_LOAD;
                        cfg_ready_q  <= 1'b0;
                        ld_groups_q  <= cfg_num_groups;
                        ld_taps_m1_q <= TAP_W'(cfg_num_taps - 5'd1);
                        wr_group_q   <= '0;
                        wr_tap_q     <= '0;
                    end else if (final_wr) begin
                        state_q     <= CFG_FULL;
                        job_ready_q <= 1'b1;
                        cfg_done_q  <= 1'b1;
                    end else if (wr_en) begin
                        if (wr_tap_q == ld_taps_m1_q) begin
                            wr_tap_q   <= '0;
                            wr_group_q <= GRP_W'(wr_group_q + 1'b1);
                        end else begin
                            wr_tap_q <= TAP_W'(wr_tap_q + 1'b1);
                        end
                    end
                end
                CFG_FULL: begin
                    if (job_accept) begin
                        state_q      <= CFG_IDLE;
                        cfg_ready_q  <= 1'b1;
                        job_ready_q  <= 1'b0;
                        exe_bank_q   <= cfg_bank_q;
                        cfg_bank_q   <= ~cfg_bank_q;
                        exe_groups_q <= ld_groups_q;
                    end
                end
                default: begin
                    state_q     <= CFG_IDLE;
                    cfg_ready_q <= 1'b1;
                    job_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Kernel group walk; a bank swap restarts at group 0.
    always_ff @(posedge clk) begin
        if (rst || swap) begin
            exe_group_q <= '0;
        end else if (next_kernel) begin
            exe_group_q <= (exe_group_q == exe_groups_q) ? '0 : GRP_W'(exe_group_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= {valid_q[LAT-2:0], ce_execute};
            last_q  <= {last_q[LAT-2:0], (exe_group_q == exe_groups_q)};
        end
    end

    for (genvar i = 0; i < int'(C_NUM_CE); i++) begin : g_ce
        cnn_layer_accel_wht_ce_port #(
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH),
            .DATA_W     (C_WHT_WIDTH),
            .ADDR_DELAY (C_SEQ_ADDR_DELAY),
            .RD_LATENCY (C_RD_LATENCY)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (cfg_data),
            .rd_addr_i ({exe_bank_q, exe_group_q, ce_seq_addr[TAP_W*i +: TAP_W]}),
            .rd_data_o (ce_wht_dout[C_WHT_WIDTH*i +: C_WHT_WIDTH])
        );
    end

    assign cfg_ready         = cfg_ready_q;
    assign job_ready         = job_ready_q;
    assign cfg_done          = cfg_done_q;
    assign ce_wht_dout_valid = valid_q[LAT-1];
    assign last_kernel       = last_q[LAT-1];

endmodule

// File: tb/tb_cnn_layer_accel_wht_bank_array.sv
// Randomized bench for the weight bank array against a linear-index bank model.
module tb_cnn_layer_accel_wht_bank_array;

    localparam int NCE = 2;
    localparam int W   = 16;
    localparam int LAT = 6;

    typedef struct packed {
        int                  due;
        logic [1:0][W-1:0]   d;
        logic [1:0]          care;
        logic                last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic [5:0]      cfg_num_groups;
    logic [4:0]      cfg_num_taps;
    logic            cfg_wren;
    logic [W-1:0]    cfg_data;
    logic            cfg_ready, cfg_done, job_ready;
    logic            job_accept;
    logic            ce_execute;
    logic [7:0]      ce_seq_addr;
    logic            next_kernel;
    logic            last_kernel;
    logic [NCE*W-1:0] ce_wht_dout;
    logic            ce_wht_dout_valid;

    always #5 clk = ~clk;

    cnn_layer_accel_wht_bank_array dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_num_groups(cfg_num_groups), .cfg_num_taps(cfg_num_taps),
        .cfg_wren(cfg_wren), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .job_accept(job_accept), .job_ready(job_ready),
        .ce_execute(ce_execute), .ce_seq_addr(ce_seq_addr),
        .next_kernel(next_kernel), .last_kernel(last_kernel),
        .ce_wht_dout(ce_wht_dout), .ce_wht_dout_valid(ce_wht_dout_valid)
    );

    // Model state: which bank loads next, which executes, and a linear write counter.
    logic [W-1:0] m_mem [2][1024];
    bit   m_loading, m_full;
    int   m_lbank, m_ebank, m_group, m_ng, m_et;
    int   m_lg, m_lt, m_widx;
    bit   allow_exe;
    exp_t pend[$];
    int   cyc;
    int   n_checks, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        bit   done_n;
        bit   swap;
        bit   in_rst;
        bit   due;
        done_n = 0;
        in_rst = rst;
        if (rst) begin
            m_loading = 0; m_full = 0; m_lbank = 0; m_ebank = 0;
            m_group = 0; m_ng = 0; m_et = 1;
            pend.delete();
        end else begin
            swap = m_full && job_accept;
            if (ce_execute) begin
                e.due  = cyc + LAT;
                e.last = (m_group == m_ng);
                for (int i = 0; i < NCE; i++) begin
                    int a;
                    a = int'((ce_seq_addr >> (4*i)) & 8'hF);
                    e.care[i] = (a < m_et);
                    e.d[i]    = m_mem[m_ebank][m_group*16 + a];
                end
                pend.push_back(e);
            end
            if (next_kernel) m_group = (m_group + 1) % (m_ng + 1);
            if (!m_full && cfg_start) begin
                m_loading = 1;
                m_lg = int'(cfg_num_groups);
                m_lt = int'(cfg_num_taps);
                m_widx = 0;
            end else if (m_loading && cfg_wren) begin
                m_mem[m_lbank][(m_widx / m_lt)*16 + (m_widx % m_lt)] = cfg_data;
                m_widx++;
                if (m_widx == (m_lg + 1) * m_lt) begin
                    m_loading = 0; m_full = 1; done_n = 1;
                end
            end else if (swap) begin
                m_full = 0;
                m_ebank = m_lbank;
                m_lbank = 1 - m_lbank;
                m_ng = m_lg;
                m_et = m_lt;
                m_group = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("cfg_ready", cfg_ready, !m_loading && !m_full);
        check("job_ready", job_ready, m_full);
        check("cfg_done", cfg_done, done_n);
        if (in_rst) begin
            check("rst_dout", ce_wht_dout, 0);
            check("rst_last", last_kernel, 0);
        end
        due = (pend.size() > 0) && (pend[0].due == cyc);
        check("valid", ce_wht_dout_valid, due);
        if (due) begin
            e = pend.pop_front();
            for (int i = 0; i < NCE; i++)
                if (e.care[i]) check($sformatf("dout_ce%0d", i), ce_wht_dout[W*i +: W], e.d[i]);
            check("last_kernel", last_kernel, e.last);
        end
    endtask

    task automatic rand_read();
        for (int i = 0; i < NCE; i++) begin
            int a;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, m_et - 1));
            ce_seq_addr[4*i +: 4] = 4'(a);
        end
        ce_execute  = allow_exe && ($urandom_range(0, 3) != 0);
        next_kernel = allow_exe && ($urandom_range(0, 5) == 0);
    endtask

    task automatic quiet();
        ce_execute = 0; next_kernel = 0; cfg_start = 0; cfg_wren = 0; job_accept = 0;
    endtask

    task automatic do_load(input int g, input int t, input bit restart, input int abort_at);
        int budget;
        bit restarted;
        restarted = 0;
        rand_read();
        cfg_start = 1; cfg_num_groups = 6'(g); cfg_num_taps = 5'(t);
        tick();
        cfg_start = 0;
        budget = 4 * (g + 1) * t + 64;
        while (m_loading && budget > 0) begin
            if (abort_at > 0 && m_widx == abort_at) break;
            rand_read();
            cfg_wren = ($urandom_range(0, 3) != 0);
            cfg_data = W'($urandom);
            if (restart && !restarted && m_widx == 3) begin
                cfg_start = 1; restarted = 1;
            end
            tick();
            cfg_start = 0; cfg_wren = 0;
            budget--;
        end
        quiet();
        if (budget == 0) check("load_budget", 1, 0);
    endtask

    task automatic accept();
        rand_read();
        job_accept = 1;
        tick();
        quiet();
    endtask

    task automatic reads(input int n);
        for (int k = 0; k < n; k++) begin
            rand_read();
            tick();
        end
        quiet();
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc = 0; allow_exe = 0;
        m_et = 1;
        rst = 1; cfg_num_groups = 0; cfg_num_taps = 1; cfg_data = 0; ce_seq_addr = 0;
        quiet();
        repeat (3) tick();
        rst = 0;

        // Stray job_accept and write while idle before any load.
        job_accept = 1; cfg_wren = 1; cfg_data = 16'hDEAD;
        tick();
        quiet();

        do_load(1, 9, 0, 0);
        // Write while FULL must not touch the finished bank.
        cfg_wren = 1; cfg_data = 16'hBEEF;
        tick();
        quiet();
        accept();
        allow_exe = 1;

        ce_execute = 1; ce_seq_addr = {4'd8, 4'd3};
        tick();
        quiet();
        repeat (LAT + 1) tick();

        for (int k = 0; k < 2; k++) begin
            next_kernel = 1;
            tick();
            quiet();
            ce_execute = 1; ce_seq_addr = {4'(k + 2), 4'(k)};
            tick();
            quiet();
            repeat (LAT + 1) tick();
        end

        // Idle-state stray accept/write with reads running.
        job_accept = 1; cfg_wren = 1; cfg_data = 16'h1234;
        tick();
        quiet();
        reads(40);

        do_load(int'($urandom_range(0, 7)), int'($urandom_range(1, 16)), 0, 0);
        reads(10);
        accept();
        reads(60);

        do_load(int'($urandom_range(0, 5)), int'($urandom_range(2, 15)), 1, 0);
        accept();
        reads(60);

        do_load(63, 16, 0, 0);
        accept();
        reads(120);

        do_load(2, 16, 0, 0);
        accept();
        reads(40);

        // Reset mid-load, then a clean reload into the reset bank pointer.
        allow_exe = 0;
        do_load(1, 9, 0, 5);
        rst = 1;
        tick();
        tick();
        rst = 0;
        reads(3);
        do_load(1, 9, 0, 0);
        accept();
        allow_exe = 1;
        reads(60);
        allow_exe = 0;
        reads(LAT + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_wht_bank_array.md
CNN_LAYER_ACCEL_WHT_BANK_ARRAY -- requirements
Module: cnn_layer_accel_wht_bank_array

Interface
REQ-001 SHALL have parameter C_NUM_CE, default 2: number of compute engines served, range 1..8.
REQ-002 SHALL have parameter C_WHT_WIDTH, default 16: weight word width.
REQ-003 SHALL have parameter C_MAX_GROUPS, default 64: kernel groups per bank, power of 2.
REQ-004 SHALL have parameter C_SEQ_ADDR_DELAY, default 3: input sequence-address pipeline stages.
REQ-005 SHALL have parameter C_RD_LATENCY, default 3: RAM read latency in cycles.
REQ-006 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port cfg_start, input, 1: pulse that opens a load into the idle bank.
REQ-009 SHALL have port cfg_num_groups, input, clog2(C_MAX_GROUPS): group count minus 1, sampled on cfg_start.
REQ-010 SHALL have port cfg_num_taps, input, 5: taps per kernel, 1..16, sampled on cfg_start.
REQ-011 SHALL have ports cfg_wren (input, 1) and cfg_data (input, C_WHT_WIDTH): weight write stream.
REQ-012 SHALL have port cfg_ready, output, 1: a load can be accepted.
REQ-013 SHALL have port cfg_done, output, 1: one-cycle pulse when a load completes.
REQ-014 SHALL have ports job_accept (input, 1) and job_ready (output, 1): bank swap handshake.
REQ-015 SHALL have port ce_execute, input, 1: read strobe for all CEs.
REQ-016 SHALL have port ce_seq_addr, input, C_NUM_CE*4: per-CE tap index; CE i uses bits [4i+3:4i].
REQ-017 SHALL have ports next_kernel (input, 1) and last_kernel (output, 1).
REQ-018 SHALL have ports ce_wht_dout (output, C_NUM_CE*C_WHT_WIDTH) and ce_wht_dout_valid (output, 1).

Function
REQ-019 SHALL hold two banks; bank address = {group, tap[3:0]}; depth C_MAX_GROUPS*16 per bank.
REQ-020 Config FSM SHALL use IDLE -> LOAD on cfg_start when cfg_ready; LOAD -> FULL on the final write, asserting cfg_done; FULL -> IDLE when the bank is swapped to execution.
REQ-021 In LOAD, each cfg_wren SHALL write to {wr_group, wr_tap}; wr_tap wraps to 0 at cfg_num_taps-1 and increments wr_group; the final write is group cfg_num_groups, tap cfg_num_taps-1.
REQ-022 cfg_wren outside LOAD SHALL be ignored; cfg_start in LOAD SHALL restart the load at {0,0}.
REQ-023 cfg_ready SHALL equal (config FSM == IDLE).
REQ-024 job_ready SHALL equal (config FSM == FULL); job_accept with job_ready low SHALL be ignored.
REQ-025 An accepted job_accept SHALL swap the execution bank, load the bank's group and tap counts, clear exe_group to 0, and return the config FSM to IDLE in the next cycle.
REQ-026 Per CE, read address {exe_bank, exe_group, seq_addr_i} SHALL be formed at input and delayed C_SEQ_ADDR_DELAY cycles.
REQ-027 ce_wht_dout_valid SHALL assert exactly C_SEQ_ADDR_DELAY+C_RD_LATENCY cycles after ce_execute, one cycle per strobe, with the matching data.
REQ-028 next_kernel SHALL increment exe_group from the next cycle; at exe_group == num_groups it SHALL wrap to 0.
REQ-029 last_kernel SHALL be aligned with ce_wht_dout_valid and high when the presented data was read from group num_groups.
REQ-030 Each CE SHALL have an independent read port; all CEs SHALL read in the same cycle with no stall.
REQ-031 Writes SHALL never target the execution bank; a read and a write in the same cycle SHALL both complete.
REQ-032 seq_addr >= num_taps SHALL return don't-care data with valid still asserted.

Reset
REQ-033 rst SHALL set: config FSM to IDLE; exe_bank, config bank pointer, counters, and exe_group to 0; all pipelines to invalid.
REQ-034 After rst, outputs SHALL be: cfg_ready 1; cfg_done 0; job_ready 0; last_kernel 0; ce_wht_dout_valid 0; ce_wht_dout 0.
REQ-035 rst in mid-load or mid-read SHALL discard all in-flight state; RAM contents are not cleared.

Structure
REQ-036 Shared package SHALL hold the config-FSM state enum, the tap-index width (4), and the max-taps constant (16).
REQ-037 A single sub-module, cnn_layer_accel_wht_ce_port, SHALL hold one replicated RAM with its address-delay pipeline; it SHALL be instantiated C_NUM_CE times, with writes broadcast to all instances.

Verification
REQ-038 Groups=2 (cfg 1), taps=9, 18 writes -> cfg_done on the 18th write, job_ready=1, cfg_ready=0.
REQ-039 job_accept, then ce_execute with CE0 addr 3 and CE1 addr 8 -> 6 cycles later valid=1, dout = words written at {0,3} and {0,8}.
REQ-040 Two next_kernel pulses with reads -> group 1 data with last_kernel=1, then wrap to group 0 with last_kernel=0.
REQ-041 Load bank B while reading bank A every cycle -> bank A data is unchanged; after swap, bank B data is read.
REQ-042 job_accept with job_ready=0, and cfg_wren in IDLE -> no bank swap and no RAM write.
REQ-043 rst asserted after the 5th load write -> cfg_ready=1, no cfg_done; a fresh 18-write load then completes normally.
